// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port driven by the OV7670 capture stage.
interface ov7670_capture_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: RGB565 byte pairs in, RGB444 pixel writes with linear addresses out.
// Runs entirely on the camera pixel clock.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic             i_pixel_clk,
  input  logic             i_reset_n,
  input  logic             i_capture_en,
  input  logic             i_cam_vsync,
  input  logic             i_cam_href,
  input  logic [7:0]       i_cam_d,
  ov7670_capture_if.master o_wr,
  output logic             o_frame_start,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [XW-1:0] XMax = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YMax = YW'(V_ACTIVE);

  typedef enum logic [1:0] {StWaitFrame, StLineWait, StByteHi, StByteLo} state_e;

  state_e            r_state;
  logic              r_vs_q, r_vs_qq, r_hr_q;
  logic [7:0]        r_d_q;
  logic [6:0]        r_hi;          // {R[3:0], G[5:3]} of the pending high byte
  logic [SW-1:0]     r_skip_cnt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [11:0]       r_wr_data;
  logic              r_frame_start, r_frame_done, r_frame_err, r_busy;

  logic              w_frame_start, w_frame_end;
  logic              w_line_short, w_x_room, w_y_room;
  logic [YW-1:0]     w_y_next;
  logic [11:0]       w_pix;

  // Register the camera inputs once; a second vsync stage gives the edge detector.
  always_ff @(posedge i_pixel_clk) begin
    if (!i_reset_n) begin
      r_vs_q  <= 1'b0;
      r_vs_qq <= 1'b0;
      r_hr_q  <= 1'b0;
      r_d_q   <= 8'h00;
    end else begin
      r_vs_q  <= i_cam_vsync;
      r_vs_qq <= r_vs_q;
      r_hr_q  <= i_cam_href;
      r_d_q   <= i_cam_d;
    end
  end

  assign w_frame_start = r_vs_qq & ~r_vs_q;
  assign w_frame_end   = ~r_vs_qq & r_vs_q;
  assign w_line_short  = (r_x != XMax);
  assign w_x_room      = (r_x < XMax);
  assign w_y_room      = (r_y < YMax);
  assign w_y_next      = (r_y == YMax) ? r_y : r_y + 1'b1;
  // R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]
  assign w_pix         = {r_hi, r_d_q[7], r_d_q[4:1]};

  // Frame/line/pixel sequencing; every output is registered here.
  always_ff @(posedge i_pixel_clk) begin
    if (!i_reset_n) begin
      r_state       <= StWaitFrame;
      r_skip_cnt    <= SW'(SKIP_FRAMES);
      r_hi          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_addr_cnt    <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (r_state != StWaitFrame && w_frame_end) begin
        // Frame end wins over a byte arriving in the same cycle; a half pixel is dropped.
        r_frame_done <= 1'b1;
        if (r_y != YMax) r_frame_err <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= StWaitFrame;
      end else begin
        unique case (r_state)
          StWaitFrame: begin
            if (w_frame_start) begin
              if (r_skip_cnt != '0) begin
                r_skip_cnt <= r_skip_cnt - 1'b1;
              end else if (i_capture_en) begin
                r_frame_start <= 1'b1;
                r_frame_err   <= 1'b0;
                r_x           <= '0;
                r_y           <= '0;
                r_addr_cnt    <= '0;
                r_busy        <= 1'b1;
                r_state       <= StLineWait;
              end
            end
          end
          StLineWait: begin
            // Lines with no bytes never leave this state, so they are not counted.
            if (r_hr_q) begin
              r_hi    <= {r_d_q[7:4], r_d_q[2:0]};
              r_state <= StByteLo;
            end
          end
          StByteHi: begin
            if (r_hr_q) begin
              r_hi    <= {r_d_q[7:4], r_d_q[2:0]};
              r_state <= StByteLo;
            end else begin
              if (w_line_short) r_frame_err <= 1'b1;
              r_x     <= '0;
              r_y     <= w_y_next;
              r_state <= StLineWait;
            end
          end
          StByteLo: begin
            if (r_hr_q) begin
              r_state <= StByteHi;
              if (w_x_room) r_x <= r_x + 1'b1;
              if (w_x_room && w_y_room) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_addr_cnt;
                r_wr_data  <= w_pix;
                r_addr_cnt <= r_addr_cnt + 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              // Odd byte count: the dangling high byte is discarded.
              r_frame_err <= 1'b1;
              r_x         <= '0;
              r_y         <= w_y_next;
              r_state     <= StLineWait;
            end
          end
          default: r_state <= StWaitFrame;
        endcase
      end
    end
  end

  assign o_wr.wr_en    = r_wr_en;
  assign o_wr.wr_addr  = r_wr_addr;
  assign o_wr.wr_data  = r_wr_data;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x4 frame.
module tb_ov7670_capture;
  localparam int unsigned H    = 8;
  localparam int unsigned V    = 4;
  localparam int unsigned AW   = 5;
  localparam int unsigned SKIP = 2;
  localparam int unsigned NPIX = H * V;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cap_en = 1'b1;
  logic       vsync  = 1'b1;
  logic       href   = 1'b0;
  logic [7:0] d      = 8'h00;
  logic       frame_start, frame_done, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_done  = 0;
  logic err_at_done = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [11:0]   wr_data_q[$];

  ov7670_capture_if #(.ADDR_W(AW)) wr_bus ();

  ov7670_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_W     (AW),
    .SKIP_FRAMES(SKIP)
  ) dut (
    .i_pixel_clk  (clk),
    .i_reset_n    (rst_n),
    .i_capture_en (cap_en),
    .i_cam_vsync  (vsync),
    .i_cam_href   (href),
    .i_cam_d      (d),
    .o_wr         (wr_bus),
    .o_frame_start(frame_start),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Record DUT activity away from the active edge.
  always @(negedge clk) begin
    if (wr_bus.wr_en) begin
      wr_addr_q.push_back(wr_bus.wr_addr);
      wr_data_q.push_back(wr_bus.wr_data);
    end
    if (frame_start) n_start++;
    if (frame_done) begin
      n_done++;
      err_at_done = frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    wr_addr_q.delete();
    wr_data_q.delete();
    n_start     = 0;
    n_done      = 0;
    err_at_done = 1'b0;
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic idle(input int n);
    href = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    href = 1'b1;
    d    = b;
    @(negedge clk);
  endtask

  // 0xF8,0x1F -> R=F, G=0, B=F
  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      drive_byte(8'hF8);
      drive_byte(8'h1F);
    end
  endtask

  task automatic send_line(input int n, input bit extra);
    send_pixels(n);
    if (extra) drive_byte(8'hF8);
    idle(2);
  endtask

  task automatic frame_begin();
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    idle(6);
  endtask

  task automatic clean_frame();
    frame_begin();
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    frame_end();
  endtask

  task automatic check_capture(input string tag, input int n_exp, input logic err_exp,
                               input logic [11:0] first_data);
    bit seq_ok;
    seq_ok = 1'b1;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== AW'(i)) seq_ok = 1'b0;
      if (wr_data_q[i] !== ((i == 0) ? first_data : 12'hF0F)) seq_ok = 1'b0;
    end
    chk({tag, ".writes"}, 32'(wr_addr_q.size()), 32'(n_exp));
    chk({tag, ".seq"}, 32'(seq_ok), 32'd1);
    chk({tag, ".start"}, 32'(n_start), (n_exp > 0) ? 32'd1 : 32'd0);
    chk({tag, ".done"}, 32'(n_done), (n_exp > 0) ? 32'd1 : 32'd0);
    chk({tag, ".err"}, 32'(err_at_done), 32'(err_exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.wr_en", 32'(wr_bus.wr_en), 32'd0);
    chk("rst.addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("rst.data", 32'(wr_bus.wr_data), 32'd0);
    chk("rst.start", 32'(frame_start), 32'd0);
    chk("rst.done", 32'(frame_done), 32'd0);
    chk("rst.err", 32'(frame_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(2);
    clear_stats();

    // Two settling frames are discarded, the third is written.
    clean_frame();
    clean_frame();
    check_capture("skip", 0, 1'b0, 12'hF0F);
    clear_stats();
    clean_frame();
    check_capture("frame3", NPIX, 1'b0, 12'hF0F);
    chk("frame3.busy", 32'(busy), 32'd0);

    // 0xA5,0xC3: R=A, G={101,1}=B, B=0001 -> 0xAB1, two edges after the low byte.
    clear_stats();
    frame_begin();
    chk("lat.busy", 32'(busy), 32'd1);
    drive_byte(8'hA5);
    drive_byte(8'hC3);
    chk("lat.edge1", 32'(wr_bus.wr_en), 32'd0);
    drive_byte(8'hF8);
    chk("lat.edge2", 32'(wr_bus.wr_en), 32'd1);
    chk("lat.data", 32'(wr_bus.wr_data), 32'hAB1);
    chk("lat.addr", 32'(wr_bus.wr_addr), 32'd0);
    drive_byte(8'h1F);
    send_pixels(H - 2);
    idle(2);
    for (int l = 1; l < V; l++) send_line(H, 1'b0);
    frame_end();
    check_capture("lat", NPIX, 1'b0, 12'hAB1);

    // One surplus pixel on line 1: dropped, error flagged and held.
    clear_stats();
    frame_begin();
    send_line(H, 1'b0);
    send_line(H + 1, 1'b0);
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    frame_end();
    check_capture("long", NPIX, 1'b1, 12'hF0F);
    chk("long.sticky", 32'(frame_err), 32'd1);

    // Error clears at the next accepted frame start.
    clear_stats();
    frame_begin();
    chk("clr.err", 32'(frame_err), 32'd0);
    for (int l = 0; l < V; l++) send_line(H, 1'b0);
    frame_end();
    check_capture("clean", NPIX, 1'b0, 12'hF0F);

    // Odd byte count on line 1; line 2 must resume at address 2*H in hi/lo phase.
    clear_stats();
    frame_begin();
    send_line(H, 1'b0);
    send_line(H, 1'b1);
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    frame_end();
    check_capture("odd", NPIX, 1'b1, 12'hF0F);

    // capture_en low at frame start, raised mid-frame: frame ignored.
    clear_stats();
    cap_en = 1'b0;
    frame_begin();
    cap_en = 1'b1;
    send_line(H, 1'b0);
    chk("noen.busy", 32'(busy), 32'd0);
    for (int l = 1; l < V; l++) send_line(H, 1'b0);
    frame_end();
    check_capture("noen", 0, 1'b0, 12'hF0F);
    clear_stats();
    clean_frame();
    check_capture("en", NPIX, 1'b0, 12'hF0F);

    // One-cycle reset mid-frame.
    clear_stats();
    frame_begin();
    send_line(H, 1'b0);
    send_pixels(2);
    rst_n = 1'b0;
    drive_byte(8'hF8);
    rst_n = 1'b1;
    chk("mrst.wr_en", 32'(wr_bus.wr_en), 32'd0);
    chk("mrst.addr", 32'(wr_bus.wr_addr), 32'd0);
    chk("mrst.data", 32'(wr_bus.wr_data), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.err", 32'(frame_err), 32'd0);
    clear_stats();
    drive_byte(8'h1F);
    send_pixels(H - 3);
    idle(2);
    for (int l = 2; l < V; l++) send_line(H, 1'b0);
    frame_end();
    chk("mrst.rest", 32'(wr_addr_q.size()), 32'd0);
    clean_frame();
    clean_frame();
    check_capture("mrst.skip", 0, 1'b0, 12'hF0F);
    clear_stats();
    clean_frame();
    check_capture("mrst.cap", NPIX, 1'b0, 12'hF0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
